uart_line_sched: RTL
====================

Name: uart_line_sched

Overview:
- Line-oriented scheduler between uart_rx, sync_fifo and uart_tx: writes every received byte into the FIFO, but releases bytes to uart_tx only in whole lines.
- A line is released once its EOL byte has been buffered. Two conditions force a flush without an EOL: the FIFO fills, or the RX line stays idle past a timeout.
- Sits in top_level in place of the free-running pass-through controller, running on the divided 153600 Hz clock.

Parameters:
- DEPTH, 16, sync_fifo depth in bytes; must equal the FIFO instance depth.
- EOL, 8'h0D, end-of-line byte.
- IDLE_TIMEOUT, 1536, clk_in cycles without RX activity (about 10 ms) before a partial line is flushed; 0 disables the timeout.

Ports:
- clk_in  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- uart_rx_valid_in  input  1  one-cycle pulse: uart_rx_data_in holds a new byte
- uart_rx_data_in  input  8  received byte
- uart_tx_ready_in  input  1  uart_tx idle and able to accept a byte
- fifo_empty_in  input  1  FIFO empty flag
- fifo_full_in  input  1  FIFO full flag
- fifo_rd_data_in  input  8  FIFO read data, valid one cycle after fifo_rd_en
- fifo_wr_en  output  1  FIFO write strobe
- fifo_wr_data_out  output  8  FIFO write data
- fifo_rd_en  output  1  FIFO read strobe
- uart_tx_en  output  1  one-cycle start pulse to uart_tx
- uart_tx_data_out  output  8  byte to transmit, held stable until the next uart_tx_en
- level_out  output  $clog2(DEPTH+1)  bytes currently buffered
- lines_out  output  $clog2(DEPTH+1)  complete lines buffered
- overflow_out  output  1  sticky: at least one byte was dropped
- draining_out  output  1  high while the state machine is outside S_IDLE

Behaviour:
- Reset (async, n_rst=0): all outputs 0; level, lines, idle counter and flush flag 0; state S_IDLE. Deasserting reset in the middle of a byte or line leaves nothing pending.
- Write path, independent of the state machine:
  - On uart_rx_valid_in with !fifo_full_in: register fifo_wr_en=1 and fifo_wr_data_out=uart_rx_data_in for exactly one cycle. Write latency is 1 cycle.
  - If the byte equals EOL, lines increments in the same cycle as the write.
  - On uart_rx_valid_in with fifo_full_in: no write; overflow_out is set and stays set until reset.
- Level accounting:
  - level increments on each write and decrements on each read.
  - A write and a read in the same cycle leave level unchanged.
  - level_out never exceeds DEPTH and never underflows.
- Idle counter:
  - Clears on every uart_rx_valid_in.
  - Otherwise increments, saturating at IDLE_TIMEOUT, while level>0.
- Flush flag is set when either of these holds:
  - level==DEPTH and lines==0 (full, with no EOL present);
  - IDLE_TIMEOUT>0, the idle counter reaches IDLE_TIMEOUT, level>0 and lines==0.
  - The flag clears when level reaches 0.
- State machine:
  - S_IDLE: when lines>0 or flush is set, and uart_tx_ready_in=1 -> S_RD.
  - S_RD: fifo_rd_en=1 for one cycle -> S_RDW.
  - S_RDW: latch fifo_rd_data_in into uart_tx_data_out -> S_TX.
  - S_TX: uart_tx_en=1 for one cycle -> S_GUARD.
  - S_GUARD: one cycle in which uart_tx_ready_in is ignored, to cover the uart_tx ready lag -> S_TXW.
  - S_TXW: wait for uart_tx_ready_in=1. Then choose the next state:
    - Sent byte was EOL: decrement lines. Go to S_RD if lines (after the decrement) >0, otherwise S_IDLE.
    - Flush set and level>0: go to S_RD.
    - Otherwise: go to S_IDLE.
- Per-byte latency from S_RD to uart_tx_en is 2 cycles. Bytes leave in FIFO order with no duplication or loss, apart from bytes dropped on overflow.
- fifo_rd_en is never asserted while fifo_empty_in=1. If the FIFO reads empty in S_RD, the state machine returns to S_IDLE (defensive path).
- Writes continue in every state. An EOL that arrives mid-drain extends the drain without a gap through S_IDLE.
- A line that grows during a flush is flushed together with the rest; the flush ends at level==0.

Test Plan:
- Line release: send 0x41 0x42 0x0D; TX output is 0x41 0x42 0x0D in order. Before the 0x0D is received, lines_out=0 and no uart_tx_en occurs. Afterwards level_out returns to 0.
- Two lines back-to-back: send "A\rB\r" while the first line is draining. lines_out peaks at 2. All 4 bytes are transmitted and draining_out drops only after the second 0x0D.
- Full flush and overflow (DEPTH=16): send 17 bytes with no EOL.
  - Byte 17 is dropped and overflow_out=1.
  - Exactly 16 bytes are transmitted and level_out ends at 0.
- Idle timeout: send 0x31 0x32, then hold RX idle. At IDLE_TIMEOUT cycles the flush starts and 2 bytes are transmitted. With IDLE_TIMEOUT=0 nothing is transmitted.
- Simultaneous events: a write and a read in the same cycle leave level_out unchanged. A slow uart_tx (ready held low for 200 cycles) produces no extra uart_tx_en pulses.
- Reset mid-drain: assert n_rst low during S_TXW. All outputs go to 0 asynchronously, and after release the block sits in S_IDLE with level_out=0 and lines_out=0.

Source files
------------

// File: rtl/uart_line_sched.sv
// uart_line_sched: buffers received bytes in an external FIFO and releases them to uart_tx a whole line at a time.
module uart_line_sched #(
  parameter int          DEPTH        = 16,
  parameter logic [7:0]  EOL          = 8'h0D,
  parameter int          IDLE_TIMEOUT = 1536
) (
  input  logic                         clk_in,
  input  logic                         n_rst,
  input  logic                         uart_rx_valid_in,
  input  logic [7:0]                   uart_rx_data_in,
  input  logic                         uart_tx_ready_in,
  input  logic                         fifo_empty_in,
  input  logic                         fifo_full_in,
  input  logic [7:0]                   fifo_rd_data_in,
  output logic                         fifo_wr_en,
  output logic [7:0]                   fifo_wr_data_out,
  output logic                         fifo_rd_en,
  output logic                         uart_tx_en,
  output logic [7:0]                   uart_tx_data_out,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic [$clog2(DEPTH+1)-1:0]   lines_out,
  output logic                         overflow_out,
  output logic                         draining_out
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_TX, S_GUARD, S_TXW} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [LW-1:0] level_nxt, lines_nxt;
  logic flush, flush_set, wr_acc, eol_in, lines_dec;
  assign wr_acc    = uart_rx_valid_in && !fifo_full_in;
  assign eol_in    = wr_acc && uart_rx_data_in == EOL;
  assign lines_dec = state == S_TXW && uart_tx_ready_in && uart_tx_data_out == EOL && lines_out != '0;
  assign flush_set = level_out != '0 && lines_out == '0 &&
                     (level_out == FULL || (IDLE_TIMEOUT > 0 && idle_cnt == IDLE_MAX));
  always_comb begin
    level_nxt = level_out + LW'(wr_acc && level_out != FULL) - LW'(fifo_rd_en && level_out != '0);
    lines_nxt = lines_out + LW'(eol_in && lines_out != FULL) - LW'(lines_dec);
  end
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      fifo_wr_en       <= 1'b0;
      fifo_wr_data_out <= '0;
      uart_tx_data_out <= '0;
      level_out        <= '0;
      lines_out        <= '0;
      overflow_out     <= 1'b0;
      idle_cnt         <= '0;
      flush            <= 1'b0;
      state            <= S_IDLE;
    end else begin
      fifo_wr_en   <= wr_acc;
      if (wr_acc) fifo_wr_data_out <= uart_rx_data_in;
      overflow_out <= overflow_out || (uart_rx_valid_in && fifo_full_in);
      level_out    <= level_nxt;
      lines_out    <= lines_nxt;
      idle_cnt     <= uart_rx_valid_in ? '0 :
                      (level_out != '0 && idle_cnt != IDLE_MAX) ? idle_cnt + IW'(1) : idle_cnt;
      flush        <= level_out == '0 ? 1'b0 : (flush || flush_set);
      if (state == S_RDW) uart_tx_data_out <= fifo_rd_data_in;
      state        <= state_nxt;
    end
  end
  always_comb begin
    state_nxt    = state;
    fifo_rd_en   = state == S_RD && !fifo_empty_in;
    uart_tx_en   = state == S_TX;
    draining_out = state != S_IDLE;
    case (state)
      S_IDLE:  state_nxt = ((lines_out != '0 || flush) && uart_tx_ready_in) ? S_RD : S_IDLE;
      S_RD:    state_nxt = fifo_empty_in ? S_IDLE : S_RDW;
      S_RDW:   state_nxt = S_TX;
      S_TX:    state_nxt = S_GUARD;
      S_GUARD: state_nxt = S_TXW;
      // a pending complete line keeps the drain going without dropping back to idle
      S_TXW:   if (uart_tx_ready_in)
                 state_nxt = (lines_nxt != '0 ||
                              (uart_tx_data_out != EOL && flush && level_out != '0)) ? S_RD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
